csr_stage: RTL and testbench

// - Machine-mode CSR unit, parallel to the execute stage (shares the EXE pipeline register).
// - Executes CSRRW/S/C(I), ECALL, MRET and the machine timer interrupt.
// - Supplies the CSR read value forwarded to MEM, plus trap redirect (flag + vector) to the core's branch-hazard logic.

---
 rtl/csr_pkg.sv | 18 +
 rtl/csr_stage.sv | 202 ++++++++++++++++++++
 tb/tb_csr_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared decode types between the decoder and the CSR stage.
package csr_pkg;

    typedef enum logic [2:0] {
        CSR_X,
        CSR_W,
        CSR_S,
        CSR_C,
        CSR_ECALL,
        CSR_MRET
    } csr_cmd_t;

    typedef struct packed {
        csr_cmd_t    csr_cmd;
        logic [31:0] op1_data;
    } ctrltype;

endpackage

// File: rtl/csr_stage.sv
// Machine-mode CSR unit beside EXE: CSR read/modify/write, ECALL, MRET and the
// machine timer interrupt, each taking one stall cycle then one commit cycle.
//
// state | meaning
// IDLE  | waiting for a new instruction id; stalls EXE on an event
// BUSY  | commit latched CSR/trap update; drive rdata and trap redirect
module csr_stage
    import csr_pkg::*;
#(
    parameter int FMAX_MHz = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_valid,
    input  logic [31:0] csr_reg_pc,
    input  logic [31:0] csr_inst,
    input  logic [63:0] csr_inst_id,
    input  ctrltype     csr_ctrl,
    output logic [31:0] csr_mem_csr_rdata,
    output logic        csr_stall_flg,
    output logic        csr_trap_flg,
    output logic [31:0] csr_trap_vector,
    input  logic [63:0] reg_cycle,
    input  logic [63:0] reg_time,
    input  logic [63:0] reg_mtime,
    input  logic [63:0] reg_mtimecmp
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t state_q, state_d;

    logic        mstatus_mie, mstatus_mpie, mie_mtie;
    logic [31:0] mtvec, mscratch, mepc, mcause;

    logic [63:0] last_id;
    logic [31:0] old_q, wdata_q, pc_q, vector_q;
    logic [11:0] waddr_q;
    logic        we_q, enter_q, irq_q, mret_q, trap_q, done_q;

    logic [11:0] addr;
    logic [31:0] op1, old_val, new_val, vector_d;
    logic        mtip, irq, wr_en, start, is_enter, is_mret, is_csr, busy_live, held;
    csr_cmd_t    cmd;

    logic unused_inst;
    assign unused_inst = &{1'b0, csr_inst[19:0]};

    assign addr = csr_inst[31:20];
    assign cmd  = csr_ctrl.csr_cmd;
    assign op1  = csr_ctrl.op1_data;
    assign mtip = reg_mtime >= reg_mtimecmp;
    assign irq  = mstatus_mie && mie_mtie && mtip;

    always_comb begin
        old_val = 32'h0;
        case (addr)
            12'h300: old_val = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
            12'h301: old_val = 32'h4000_0100;
            12'h304: old_val = {24'h0, mie_mtie, 7'h0};
            12'h305: old_val = mtvec;
            12'h340: old_val = mscratch;
            12'h341: old_val = mepc;
            12'h342: old_val = mcause;
            12'h344: old_val = {24'h0, mtip, 7'h0};
            12'hC00, 12'hB00: old_val = reg_cycle[31:0];
            12'hC80, 12'hB80: old_val = reg_cycle[63:32];
            12'hC01: old_val = reg_time[31:0];
            12'hC81: old_val = reg_time[63:32];
            12'hFC0: old_val = 32'(FMAX_MHz);
            default: old_val = 32'h0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        wr_en   = 1'b0;
        case (cmd)
            CSR_W: begin
                new_val = op1;
                wr_en   = 1'b1;
            end
            CSR_S: begin
                new_val = old_val | op1;
                wr_en   = op1 != 32'h0;
            end
            CSR_C: begin
                new_val = old_val & ~op1;
                wr_en   = op1 != 32'h0;
            end
            default: begin
                new_val = old_val;
                wr_en   = 1'b0;
            end
        endcase
    end

    // The interrupt preempts whatever instruction sits in EXE.
    assign is_enter = irq || (cmd == CSR_ECALL);
    assign is_mret  = !irq && (cmd == CSR_MRET);
    assign is_csr   = !irq && ((cmd == CSR_W) || (cmd == CSR_S) || (cmd == CSR_C));
    assign vector_d = is_enter ? {mtvec[31:2], 2'b00} : mepc;

    assign start     = (state_q == S_IDLE) && csr_valid && (csr_inst_id != last_id)
                       && ((cmd != CSR_X) || irq);
    assign busy_live = (state_q == S_BUSY) && csr_valid;
    assign held      = (state_q == S_IDLE) && csr_valid && (csr_inst_id == last_id) && done_q;

    always_comb begin
        state_d       = state_q;
        csr_stall_flg = 1'b0;
        case (state_q)
            S_IDLE: begin
                csr_stall_flg = start;
                if (start) state_d = S_BUSY;
            end
            S_BUSY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign csr_trap_flg      = busy_live && trap_q;
    assign csr_trap_vector   = vector_q;
    assign csr_mem_csr_rdata = (busy_live || held) ? old_q : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_id  <= '1;
            old_q    <= 32'h0;
            wdata_q  <= 32'h0;
            waddr_q  <= 12'h0;
            pc_q     <= 32'h0;
            vector_q <= 32'h0;
            we_q     <= 1'b0;
            enter_q  <= 1'b0;
            irq_q    <= 1'b0;
            mret_q   <= 1'b0;
            trap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            last_id  <= csr_inst_id;
            old_q    <= is_csr ? old_val : 32'h0;
            wdata_q  <= new_val;
            waddr_q  <= addr;
            pc_q     <= csr_reg_pc;
            vector_q <= vector_d;
            we_q     <= is_csr && wr_en;
            enter_q  <= is_enter;
            irq_q    <= irq;
            mret_q   <= is_mret;
            trap_q   <= is_enter || is_mret;
            done_q   <= 1'b0;
        end else if (state_q == S_BUSY) begin
            done_q <= csr_valid;
        end
    end

    // Architectural state only changes in BUSY, and only if EXE was not flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mtvec        <= 32'h0;
            mscratch     <= 32'h0;
            mepc         <= 32'h0;
            mcause       <= 32'h0;
        end else if (busy_live) begin
            if (enter_q) begin
                mepc         <= pc_q;
                mcause       <= irq_q ? 32'h8000_0007 : 32'd11;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_q) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (we_q) begin
                case (waddr_q)
                    12'h300: begin
                        mstatus_mie  <= wdata_q[3];
                        mstatus_mpie <= wdata_q[7];
                    end
                    12'h304: mie_mtie <= wdata_q[7];
                    12'h305: mtvec    <= wdata_q;
                    12'h340: mscratch <= wdata_q;
                    12'h341: mepc     <= wdata_q;
                    12'h342: mcause   <= wdata_q;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_stage.sv
// Directed bench for csr_stage: a table of CSR accesses with hand-computed old
// values, then sequences for traps, MRET, interrupts, held ids, flush and reset.
module tb_csr_stage;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [31:0] csr_reg_pc;
    logic [31:0] csr_inst;
    logic [63:0] csr_inst_id;
    ctrltype     csr_ctrl;
    logic [31:0] csr_mem_csr_rdata;
    logic        csr_stall_flg;
    logic        csr_trap_flg;
    logic [31:0] csr_trap_vector;
    logic [63:0] reg_cycle, reg_time, reg_mtime, reg_mtimecmp;

    int checks = 0;
    int errors = 0;
    logic [63:0] next_id = 64'h10;

    always #5 clk = ~clk;

    csr_stage #(.FMAX_MHz(27)) dut (
        .clk               (clk),
        .rst               (rst),
        .csr_valid         (csr_valid),
        .csr_reg_pc        (csr_reg_pc),
        .csr_inst          (csr_inst),
        .csr_inst_id       (csr_inst_id),
        .csr_ctrl          (csr_ctrl),
        .csr_mem_csr_rdata (csr_mem_csr_rdata),
        .csr_stall_flg     (csr_stall_flg),
        .csr_trap_flg      (csr_trap_flg),
        .csr_trap_vector   (csr_trap_vector),
        .reg_cycle         (reg_cycle),
        .reg_time          (reg_time),
        .reg_mtime         (reg_mtime),
        .reg_mtimecmp      (reg_mtimecmp)
    );

    typedef struct {
        csr_cmd_t    cmd;
        logic [11:0] addr;
        logic [31:0] op1;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input csr_cmd_t c, input logic [11:0] a, input logic [31:0] o,
                       input logic [31:0] e);
        vec_t v;
        v.cmd = c; v.addr = a; v.op1 = o; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input csr_cmd_t c, input logic [11:0] a, input logic [31:0] o,
                         input logic [31:0] pc);
        csr_valid        = 1'b1;
        csr_reg_pc       = pc;
        csr_inst         = {a, 20'h00073};
        csr_ctrl.csr_cmd = c;
        csr_ctrl.op1_data = o;
        csr_inst_id      = next_id;
        next_id          = next_id + 1;
    endtask

    task automatic exec(input csr_cmd_t c, input logic [11:0] a, input logic [31:0] o,
                        input logic [31:0] pc, output logic st1, output logic st2,
                        output logic [31:0] rd, output logic tf, output logic [31:0] tv);
        @(posedge clk); #1;
        drive(c, a, o, pc);
        @(negedge clk);
        st1 = csr_stall_flg;
        @(negedge clk);
        st2 = csr_stall_flg;
        rd  = csr_mem_csr_rdata;
        tf  = csr_trap_flg;
        tv  = csr_trap_vector;
        @(posedge clk); #1;
        csr_valid = 1'b0;
    endtask

    task automatic rd_csr(input logic [11:0] a, input logic [31:0] exp, input string name);
        logic s1, s2, tf;
        logic [31:0] rd, tv;
        exec(CSR_S, a, 32'h0, 32'h0, s1, s2, rd, tf, tv);
        check(name, rd, exp);
    endtask

    task automatic trap_op(input csr_cmd_t c, input logic [31:0] pc, input logic [31:0] exp_vec,
                           input string name);
        logic s1, s2, tf;
        logic [31:0] rd, tv;
        exec(c, 12'h000, 32'h0, pc, s1, s2, rd, tf, tv);
        check({name, "_stall"}, 32'(s1), 32'd1);
        check({name, "_trap"}, 32'(tf), 32'd1);
        check({name, "_vector"}, tv, exp_vec);
    endtask

    initial begin
        logic s1, s2, tf;
        logic [31:0] rd, tv;
        int stalls;

        rst = 1'b1;
        csr_valid = 1'b0;
        csr_reg_pc = 32'h0;
        csr_inst = 32'h0;
        csr_inst_id = 64'h0;
        csr_ctrl.csr_cmd = CSR_X;
        csr_ctrl.op1_data = 32'h0;
        reg_cycle = 64'h1_0000_0002;
        reg_time = 64'h0000_0005_0000_0007;
        reg_mtime = 64'd0;
        reg_mtimecmp = 64'd5;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_stall", 32'(csr_stall_flg), 32'd0);
        check("reset_trap", 32'(csr_trap_flg), 32'd0);
        check("reset_rdata", csr_mem_csr_rdata, 32'h0);
        check("reset_vector", csr_trap_vector, 32'h0);

        add(CSR_W, 12'h340, 32'hDEADBEEF, 32'h0);
        add(CSR_S, 12'h340, 32'h0,        32'hDEADBEEF);
        add(CSR_C, 12'h340, 32'h0000FFFF, 32'hDEADBEEF);
        add(CSR_S, 12'h340, 32'h0,        32'hDEAD0000);
        add(CSR_W, 12'h301, 32'h0,        32'h40000100);
        add(CSR_S, 12'h301, 32'h0,        32'h40000100);
        add(CSR_W, 12'h300, 32'hFFFFFFFF, 32'h0);
        add(CSR_S, 12'h300, 32'h0,        32'h00000088);
        add(CSR_C, 12'h300, 32'h00000080, 32'h00000088);
        add(CSR_W, 12'h300, 32'h0,        32'h00000008);
        add(CSR_W, 12'h304, 32'hFFFFFFFF, 32'h0);
        add(CSR_S, 12'h304, 32'h0,        32'h00000080);
        add(CSR_S, 12'hC80, 32'h0,        32'h1);
        add(CSR_S, 12'hC00, 32'h0,        32'h2);
        add(CSR_S, 12'hB80, 32'h0,        32'h1);
        add(CSR_S, 12'hB00, 32'h0,        32'h2);
        add(CSR_S, 12'hC01, 32'h0,        32'h7);
        add(CSR_S, 12'hC81, 32'h0,        32'h5);
        add(CSR_S, 12'hF14, 32'h0,        32'h0);
        add(CSR_S, 12'hFC0, 32'h0,        32'd27);
        add(CSR_W, 12'h343, 32'h5,        32'h0);
        add(CSR_S, 12'h343, 32'h0,        32'h0);
        add(CSR_W, 12'h7C0, 32'h1,        32'h0);
        add(CSR_S, 12'h7C0, 32'h0,        32'h0);
        add(CSR_S, 12'h344, 32'h0,        32'h0);
        add(CSR_W, 12'h305, 32'h201,      32'h0);
        add(CSR_S, 12'h305, 32'h0,        32'h201);
        add(CSR_W, 12'h342, 32'h3,        32'h0);
        add(CSR_S, 12'h342, 32'h0,        32'h3);
        add(CSR_W, 12'h300, 32'h8,        32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            exec(tbl[i].cmd, tbl[i].addr, tbl[i].op1, 32'h0, s1, s2, rd, tf, tv);
            check($sformatf("vec%0d_stall1", i), 32'(s1), 32'd1);
            check($sformatf("vec%0d_stall2", i), 32'(s2), 32'd0);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
            check($sformatf("vec%0d_trap", i), 32'(tf), 32'd0);
        end
        @(negedge clk);
        check("idle_rdata", csr_mem_csr_rdata, 32'h0);

        // Timer interrupt taken on a plain ADD (MIE=1, MTIE=1 from the table).
        reg_mtime = 64'd10;
        trap_op(CSR_X, 32'h40, 32'h200, "irq");
        reg_mtime = 64'd0;
        rd_csr(12'h342, 32'h80000007, "irq_mcause");
        rd_csr(12'h341, 32'h40, "irq_mepc");
        rd_csr(12'h300, 32'h80, "irq_mstatus");
        reg_mtime = 64'd10;
        rd_csr(12'h344, 32'h80, "mip_mtip");
        reg_mtime = 64'd0;

        exec(CSR_W, 12'h300, 32'h8, 32'h0, s1, s2, rd, tf, tv);
        check("mie_set_old", rd, 32'h80);
        trap_op(CSR_ECALL, 32'h100, 32'h200, "ecall");
        rd_csr(12'h341, 32'h100, "ecall_mepc");
        rd_csr(12'h342, 32'd11, "ecall_mcause");
        rd_csr(12'h300, 32'h80, "ecall_mstatus");

        exec(CSR_W, 12'h341, 32'h104, 32'h0, s1, s2, rd, tf, tv);
        check("mepc_write_old", rd, 32'h100);
        trap_op(CSR_MRET, 32'h200, 32'h104, "mret");
        rd_csr(12'h300, 32'h88, "mret_mstatus");

        exec(CSR_X, 12'h000, 32'h0, 32'h44, s1, s2, rd, tf, tv);
        check("plain_no_stall", 32'(s1), 32'd0);
        check("plain_no_trap", 32'(tf), 32'd0);

        // Same id held for 5 cycles: one stall, rdata stable afterwards.
        @(posedge clk); #1;
        drive(CSR_S, 12'h340, 32'h1, 32'h0);
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (csr_stall_flg) stalls++;
            if (i >= 1) check($sformatf("held_rdata%0d", i), csr_mem_csr_rdata, 32'hDEAD0000);
            @(posedge clk); #1;
        end
        csr_valid = 1'b0;
        check("held_stalls", 32'(stalls), 32'd1);
        rd_csr(12'h340, 32'hDEAD0001, "held_mscratch");

        // Flush while BUSY drops both the write and the trap.
        @(posedge clk); #1;
        drive(CSR_W, 12'h340, 32'h12345678, 32'h0);
        @(posedge clk); #1 csr_valid = 1'b0;
        @(negedge clk);
        check("flush_rdata", csr_mem_csr_rdata, 32'h0);
        rd_csr(12'h340, 32'hDEAD0001, "flush_mscratch");
        @(posedge clk); #1;
        drive(CSR_ECALL, 12'h000, 32'h0, 32'h300);
        @(posedge clk); #1 csr_valid = 1'b0;
        @(negedge clk);
        check("flush_trap", 32'(csr_trap_flg), 32'd0);
        rd_csr(12'h341, 32'h104, "flush_mepc");

        // Reset while BUSY.
        @(posedge clk); #1;
        drive(CSR_W, 12'h340, 32'hCAFEF00D, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        csr_valid = 1'b0;
        @(negedge clk);
        check("rstbusy_trap", 32'(csr_trap_flg), 32'd0);
        check("rstbusy_rdata", csr_mem_csr_rdata, 32'h0);
        rd_csr(12'h340, 32'h0, "rstbusy_mscratch");
        rd_csr(12'h305, 32'h0, "rstbusy_mtvec");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
